// File: rtl/lsu_axi_master.sv
// AXI4-Lite master for the load/store unit: one load (AR/R) or store (AW/W/B) at a time,
// with byte-lane placement of store data and extension of load data.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] maxi_araddr,
  output logic              maxi_arvalid,
  input  logic              maxi_arready,
  input  logic [DATA_W-1:0] maxi_rdata,
  input  logic              maxi_rvalid,
  output logic              maxi_rready,
  output logic [ADDR_W-1:0] maxi_awaddr,
  output logic              maxi_awvalid,
  input  logic              maxi_awready,
  output logic [DATA_W-1:0] maxi_wdata,
  output logic [DATA_W/8-1:0] maxi_wstrb,
  output logic              maxi_wvalid,
  input  logic              maxi_wready,
  input  logic              maxi_bvalid,
  output logic              maxi_bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;

  state_t              r_state, w_next;
  logic                r_req_ready, r_aw_done, r_w_done, r_signed;
  logic [1:0]          r_size, r_lane;
  logic                w_accept, w_aw_hs, w_w_hs;
  logic [3:0]          w_strb;
  logic [DATA_W-1:0]   w_wdat, w_ld;
  logic [7:0]          w_b;
  logic [15:0]         w_h;

  assign w_accept     = (r_state == IDLE) && r_req_ready && req_valid;
  assign req_ready    = r_req_ready;
  assign maxi_arvalid = (r_state == AR);
  assign maxi_rready  = (r_state == R);
  assign maxi_awvalid = (r_state == AW_W) && !r_aw_done;
  assign maxi_wvalid  = (r_state == AW_W) && !r_w_done;
  assign maxi_bready  = (r_state == B);
  assign resp_valid   = (r_state == RESP);
  assign w_aw_hs      = maxi_awvalid && maxi_awready;
  assign w_w_hs       = maxi_wvalid && maxi_wready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = req_wen ? AW_W : AR;
      AR:   if (maxi_arready) w_next = R;
      R:    if (maxi_rvalid) w_next = RESP;
      AW_W: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = B;
      B:    if (maxi_bvalid) w_next = RESP;
      RESP: if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Store lane placement is resolved at accept time so W carries registered values.
  always_comb begin
    w_strb = 4'b1111;
    w_wdat = req_wdata;
    case (req_size)
      2'd0: begin
        w_strb = 4'b0001 << req_addr[1:0];
        w_wdat = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_strb = 4'b0011 << {req_addr[1], 1'b0};
        w_wdat = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_b = maxi_rdata[{r_lane, 3'b000} +: 8];
  assign w_h = maxi_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_ld = maxi_rdata;
    case (r_size)
      2'd0:    w_ld = {{24{r_signed & w_b[7]}}, w_b};
      2'd1:    w_ld = {{16{r_signed & w_h[15]}}, w_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= 2'd0;
      r_lane      <= 2'd0;
      maxi_araddr <= '0;
      maxi_awaddr <= '0;
      maxi_wdata  <= '0;
      maxi_wstrb  <= '0;
      resp_rdata  <= '0;
    end else begin
      r_req_ready <= (w_next == IDLE);
      if (w_accept) begin
        r_size     <= req_size;
        r_lane     <= req_addr[1:0];
        r_signed   <= req_signed;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
        resp_rdata <= '0;
        if (req_wen) begin
          maxi_awaddr <= req_addr;
          maxi_wdata  <= w_wdat;
          maxi_wstrb  <= w_strb;
        end else begin
          maxi_araddr <= req_addr;
        end
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (r_state == R && maxi_rvalid) resp_rdata <= w_ld;
      if (r_state == B && maxi_bvalid) resp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Scoreboard bench for lsu_axi_master: AXI-Lite slave model with programmable ready delays.
module tb_lsu_axi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, req_wen, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [31:0] maxi_araddr, maxi_rdata, maxi_awaddr, maxi_wdata;
  logic        maxi_arvalid, maxi_arready, maxi_rvalid, maxi_rready;
  logic        maxi_awvalid, maxi_awready, maxi_wvalid, maxi_wready;
  logic        maxi_bvalid, maxi_bready;
  logic [3:0]  maxi_wstrb;

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .maxi_araddr(maxi_araddr), .maxi_arvalid(maxi_arvalid), .maxi_arready(maxi_arready),
    .maxi_rdata(maxi_rdata), .maxi_rvalid(maxi_rvalid), .maxi_rready(maxi_rready),
    .maxi_awaddr(maxi_awaddr), .maxi_awvalid(maxi_awvalid), .maxi_awready(maxi_awready),
    .maxi_wdata(maxi_wdata), .maxi_wstrb(maxi_wstrb), .maxi_wvalid(maxi_wvalid),
    .maxi_wready(maxi_wready), .maxi_bvalid(maxi_bvalid), .maxi_bready(maxi_bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [31:0] exp_resp[$];
  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];

  int          ar_delay, r_delay, aw_delay, w_delay;
  bit          spur;
  logic [31:0] rd_data;
  int          ar_hs, ar_cyc, ar_unstable, aw_cyc, w_cyc, b_hs, resp_cnt;
  logic [31:0] w_last_dat;
  logic [3:0]  w_last_strb;

  function automatic logic [31:0] ld_model(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    int                 v;
    sh  = rd >> (8 * a);
    sb  = sh[7:0];
    shw = sh[15:0];
    case (sz)
      2'd0:    v = sg ? int'(sb) : int'(sh[7:0]);
      2'd1:    v = sg ? int'(shw) : int'(sh[15:0]);
      default: v = int'(rd);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [35:0] st_model(input logic [31:0] d, input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] wd;
    logic [3:0]  sb;
    int          nb;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = d[8*(i % nb) +: 8];
      sb[i] = (i >= int'(a)) && (i < int'(a) + nb);
    end
    return {sb, wd};
  endfunction

  // Slave model and response monitor act 1 time unit after each negedge.
  initial begin
    int          ar_wait, r_wait, aw_wait, w_wait;
    bit          ar_pv;
    logic [31:0] ar_pa;
    logic [35:0] ew;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; ar_pv = 0; ar_pa = 0;
    maxi_arready = 0; maxi_rvalid = 0; maxi_rdata = 0; maxi_awready = 0;
    maxi_wready = 0; maxi_bvalid = 0;
    forever begin
      @(negedge clk); #1;
      if (maxi_arvalid) begin
        ar_cyc++;
        if (ar_pv && maxi_araddr !== ar_pa) ar_unstable++;
        ar_pv = 1; ar_pa = maxi_araddr;
        maxi_arready = (ar_wait >= ar_delay);
        ar_wait++;
        if (maxi_arready) begin
          ar_hs++;
          if (exp_ar.size() != 0) check_eq("araddr", maxi_araddr, exp_ar.pop_front());
          else check_eq("ar_unexpected", maxi_arvalid, 0);
        end
      end else begin
        maxi_arready = 0; ar_wait = 0; ar_pv = 0;
      end
      if (maxi_rready && r_wait >= r_delay) begin
        maxi_rvalid = 1; maxi_rdata = rd_data;
      end else begin
        maxi_rvalid = spur && !maxi_rready; maxi_rdata = $urandom;
      end
      r_wait = maxi_rready ? r_wait + 1 : 0;
      if (maxi_awvalid) begin
        aw_cyc++;
        maxi_awready = (aw_wait >= aw_delay);
        aw_wait++;
        if (maxi_awready) begin
          if (exp_aw.size() != 0) check_eq("awaddr", maxi_awaddr, exp_aw.pop_front());
          else check_eq("aw_unexpected", maxi_awvalid, 0);
        end
      end else begin
        maxi_awready = 0; aw_wait = 0;
      end
      if (maxi_wvalid) begin
        w_cyc++;
        maxi_wready = (w_wait >= w_delay);
        w_wait++;
        if (maxi_wready) begin
          w_last_dat = maxi_wdata; w_last_strb = maxi_wstrb;
          if (exp_w.size() != 0) begin
            ew = exp_w.pop_front();
            check_eq("wdata", maxi_wdata, ew[31:0]);
            check_eq("wstrb", maxi_wstrb, ew[35:32]);
          end else check_eq("w_unexpected", maxi_wvalid, 0);
        end
      end else begin
        maxi_wready = 0; w_wait = 0;
      end
      maxi_bvalid = maxi_bready ? 1'b1 : spur;
      if (maxi_bvalid && maxi_bready) b_hs++;
      if (resp_valid && resp_ready) begin
        resp_cnt++;
        if (exp_resp.size() != 0) check_eq("resp_rdata", resp_rdata, exp_resp.pop_front());
        else check_eq("resp_unexpected", resp_valid, 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst && req_valid && req_ready)
        assert (!((req_size == 2'd1 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'd0)))
          else $error("misaligned request addr=%h size=%0d", req_addr, req_size);
    end
  end

  task automatic issue(input logic [31:0] addr, input logic wen, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sg, input logic [31:0] exp, input bit want);
    int n;
    @(negedge clk);
    req_valid = 1; req_addr = addr; req_wen = wen; req_wdata = wd; req_size = sz; req_signed = sg;
    if (wen) begin
      exp_aw.push_back(addr);
      exp_w.push_back(st_model(wd, addr[1:0], sz));
    end else exp_ar.push_back(addr);
    if (want) exp_resp.push_back(exp);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) check_eq("req_accept_timeout", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_resp.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_resp.size() != 0) begin
      check_eq("resp_timeout", exp_resp.size(), 0);
      exp_resp.delete();
    end
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic wen, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sg, input logic [31:0] exp);
    issue(addr, wen, wd, sz, sg, exp, 1'b1);
    wait_done();
  endtask

  initial begin
    int          lat, n, rc;
    logic [1:0]  sz, a;
    logic        wen, sg;
    logic [31:0] wd, ex;
    rst = 1; req_valid = 0; req_addr = 0; req_wen = 0; req_wdata = 0; req_size = 0; req_signed = 0;
    resp_ready = 1; ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; spur = 0; rd_data = 0;
    ar_hs = 0; ar_cyc = 0; ar_unstable = 0; aw_cyc = 0; w_cyc = 0; b_hs = 0; resp_cnt = 0;
    w_last_dat = 0; w_last_strb = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_valids", {maxi_arvalid, maxi_rready, maxi_awvalid, maxi_wvalid, maxi_bready, resp_valid}, 0);
    check_eq("rst_addrs", {maxi_araddr, maxi_awaddr}, 0);
    check_eq("rst_data", {maxi_wdata, resp_rdata}, 0);
    check_eq("rst_wstrb", maxi_wstrb, 0);
    rst = 0;
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1);

    // LB signed with latency measurement
    rd_data = 32'h80FF1234;
    issue(32'h80000003, 0, 0, 2'd0, 1, 32'hFFFFFF80, 1'b1);
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    check_eq("load_latency", lat, 3);
    wait_done();
    do_txn(32'h80000003, 0, 0, 2'd0, 0, 32'h00000080);
    rd_data = 32'h80017FFF;
    do_txn(32'h80000002, 0, 0, 2'd1, 1, 32'hFFFF8001);

    // LW with arready delayed 3 cycles
    ar_delay = 3; ar_hs = 0; ar_cyc = 0; ar_unstable = 0; rd_data = 32'hCAFEF00D;
    do_txn(32'h80000008, 0, 0, 2'd2, 0, 32'hCAFEF00D);
    check_eq("lw_ar_handshakes", ar_hs, 1);
    check_eq("lw_ar_cycles", ar_cyc, 4);
    check_eq("lw_araddr_unstable", ar_unstable, 0);
    ar_delay = 0;

    // SB with garbage above the byte
    do_txn(32'h80000001, 1, 32'h123456AB, 2'd0, 0, 32'h0);
    check_eq("sb_wstrb", w_last_strb, 4'b0010);
    check_eq("sb_wdata", w_last_dat, 32'hABABABAB);

    // SW with awready at cycle 1, wready at cycle 4
    aw_delay = 0; w_delay = 3; aw_cyc = 0; w_cyc = 0; b_hs = 0; rc = resp_cnt;
    do_txn(32'h80000010, 1, 32'h11223344, 2'd2, 0, 32'h0);
    check_eq("sw_aw_cycles", aw_cyc, 1);
    check_eq("sw_w_cycles", w_cyc, 4);
    check_eq("sw_b_handshakes", b_hs, 1);
    check_eq("sw_resp_count", resp_cnt - rc, 1);
    w_delay = 0;

    // Response held by WBU for 5 cycles
    resp_ready = 0; rd_data = 32'hBEEF0000;
    issue(32'h80000022, 0, 0, 2'd1, 0, 32'h0000BEEF, 1'b1);
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_resp_valid", resp_valid, 1);
      check_eq("hold_resp_rdata", resp_rdata, 32'h0000BEEF);
      check_eq("hold_req_ready", req_ready, 0);
      @(negedge clk);
    end
    resp_ready = 1;
    wait_done();

    // Reset while waiting in R: no response may follow
    r_delay = 1000;
    issue(32'h80000030, 0, 0, 2'd2, 0, 32'h0, 1'b0);
    n = 0;
    while (!maxi_rready && n < 50) begin @(negedge clk); n++; end
    check_eq("rst_mid_in_r", maxi_rready, 1);
    rc = resp_cnt;
    rst = 1;
    @(negedge clk);
    check_eq("rst_mid_valids", {maxi_arvalid, maxi_rready, maxi_awvalid, maxi_wvalid, maxi_bready, resp_valid}, 0);
    @(negedge clk);
    r_delay = 0; rst = 0;
    repeat (4) @(negedge clk);
    check_eq("rst_mid_no_resp", resp_cnt - rc, 0);
    rd_data = 32'h0000007F;
    do_txn(32'h80000040, 0, 0, 2'd0, 1, 32'h0000007F);

    // Randomised mix with spurious rvalid/bvalid outside R/B
    spur = 1;
    for (int i = 0; i < 16; i++) begin
      sz  = 2'($urandom_range(0, 3));
      a   = (sz == 2'd0) ? 2'($urandom_range(0, 3)) : (sz == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
      wen = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      rd_data  = $urandom;
      ar_delay = $urandom_range(0, 2); r_delay = $urandom_range(0, 2);
      aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2);
      ex = wen ? 32'h0 : ld_model(rd_data, a, sz, sg);
      do_txn(32'h80000100 + 32'(4 * i) + {30'd0, a}, wen, wd, sz, sg, ex);
    end
    spur = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
